// File: rtl/draw_seq_pkg.sv
// Shared types and constants for the frame draw sequencer.
package draw_seq_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        LOAD,
        DRAW,
        COL,
        COL_WAIT,
        INC,
        CHANGE
    } state_t;

    localparam int unsigned BLACK       = 0;
    localparam logic        PASS_ERASE  = 1'b0;
    localparam logic        PASS_COLOUR = 1'b1;

endpackage

// File: rtl/draw_window_counter.sv
// Free-running window counter: synchronous clear, increment enable, wraps at 2^CNT_W.
module draw_window_counter #(
    parameter int unsigned CNT_W = 20
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (inc) begin
            count <= count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/draw_sequencer.sv
// Frame sequencer: erase pass, logic step, colour pass; muxes one layer (or the
// override stream) onto the shared VGA write port.
module draw_sequencer
    import draw_seq_pkg::*;
#(
    parameter int unsigned NUM_LAYERS = 3,
    parameter int unsigned XW         = 10,
    parameter int unsigned CW         = 3,
    parameter int unsigned CNT_W      = 20
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        enable,
    input  logic [NUM_LAYERS-1:0]       erase_mask,
    input  logic [NUM_LAYERS-1:0]       draw_mask,
    input  logic [NUM_LAYERS*CNT_W-1:0] layer_delay,
    input  logic [CNT_W-1:0]            logic_delay,
    input  logic [NUM_LAYERS-1:0]       layer_done,
    input  logic [NUM_LAYERS*XW-1:0]    layer_x,
    input  logic [NUM_LAYERS*XW-1:0]    layer_y,
    input  logic [NUM_LAYERS*CW-1:0]    layer_colour,
    input  logic [NUM_LAYERS-1:0]       layer_en,
    input  logic                        ovr_active,
    input  logic [XW-1:0]               ovr_x,
    input  logic [XW-1:0]               ovr_y,
    input  logic [CW-1:0]               ovr_colour,
    input  logic                        ovr_en,
    input  logic                        clear_overrun,
    output logic [NUM_LAYERS-1:0]       layer_go,
    output logic                        logic_go,
    output logic                        inc_enable,
    output logic                        pass,
    output logic                        busy,
    output logic                        overrun,
    output logic [XW-1:0]               x,
    output logic [XW-1:0]               y,
    output logic [CW-1:0]               colour,
    output logic                        plot
);

    localparam int unsigned IW = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

    state_t                state_q;
    logic [IW-1:0]         idx_q;
    logic                  at_end_q;
    logic [CNT_W-1:0]      count;
    logic [NUM_LAYERS-1:0] mask;
    logic                  sel_found;
    logic [IW-1:0]         sel_idx;
    logic [NUM_LAYERS-1:0] sel_onehot;
    logic [CNT_W-1:0]      cur_delay;
    logic                  cur_done;
    logic [XW-1:0]         cur_x;
    logic [XW-1:0]         cur_y;
    logic [CW-1:0]         cur_colour;

    draw_window_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .reset (reset),
        .clear ((state_q == LOAD) || (state_q == COL)),
        .inc   ((state_q == DRAW) || (state_q == COL_WAIT)),
        .count (count)
    );

    // Lowest enabled slot at or above idx; at_end means the last slot was already drawn.
    always_comb begin
        mask      = (pass == PASS_COLOUR) ? draw_mask : erase_mask;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = NUM_LAYERS - 1; i >= 0; i--) begin
            if (!at_end_q && (i >= int'(idx_q)) && mask[i]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(i);
            end
        end
        sel_onehot = NUM_LAYERS'(1) << sel_idx;
    end

    always_comb begin
        cur_delay  = layer_delay[int'(idx_q)*CNT_W +: CNT_W];
        cur_done   = layer_done[idx_q];
        cur_x      = layer_x[int'(idx_q)*XW +: XW];
        cur_y      = layer_y[int'(idx_q)*XW +: XW];
        cur_colour = layer_colour[int'(idx_q)*CW +: CW];
    end

    assign busy = (state_q != IDLE);

    always_comb begin
        x      = cur_x;
        y      = cur_y;
        colour = cur_colour;
        plot   = 1'b0;
        if (ovr_active) begin
            x      = ovr_x;
            y      = ovr_y;
            colour = ovr_colour;
            plot   = ovr_en;
        end else if ((state_q == LOAD) || (state_q == DRAW)) begin
            plot = layer_en[idx_q];
            if (pass == PASS_ERASE) begin
                colour = CW'(BLACK);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pass       <= PASS_ERASE;
            idx_q      <= '0;
            at_end_q   <= 1'b0;
            overrun    <= 1'b0;
            layer_go   <= '0;
            logic_go   <= 1'b0;
            inc_enable <= 1'b0;
        end else begin
            layer_go   <= '0;
            logic_go   <= 1'b0;
            inc_enable <= 1'b0;

            // A tick arriving mid-frame is dropped; a simultaneous clear loses.
            if (enable && (state_q != IDLE)) begin
                overrun <= 1'b1;
            end else if (clear_overrun) begin
                overrun <= 1'b0;
            end

            case (state_q)
                IDLE: begin
                    if (enable && !ovr_active) begin
                        state_q  <= SELECT;
                        pass     <= PASS_ERASE;
                        idx_q    <= '0;
                        at_end_q <= 1'b0;
                    end
                end
                SELECT: begin
                    if (sel_found) begin
                        idx_q    <= sel_idx;
                        layer_go <= sel_onehot;
                        state_q  <= LOAD;
                    end else if (pass == PASS_ERASE) begin
                        logic_go <= 1'b1;
                        state_q  <= COL;
                    end else begin
                        state_q <= CHANGE;
                    end
                end
                LOAD: state_q <= DRAW;
                DRAW: begin
                    if ((count == cur_delay) || cur_done) begin
                        state_q <= SELECT;
                        if (idx_q == IW'(NUM_LAYERS - 1)) begin
                            at_end_q <= 1'b1;
                        end else begin
                            idx_q <= idx_q + IW'(1);
                        end
                    end
                end
                COL: state_q <= COL_WAIT;
                COL_WAIT: begin
                    if (count == logic_delay) begin
                        inc_enable <= 1'b1;
                        state_q    <= INC;
                    end
                end
                INC: state_q <= CHANGE;
                CHANGE: begin
                    pass <= ~pass;
                    if (pass == PASS_ERASE) begin
                        idx_q    <= '0;
                        at_end_q <= 1'b0;
                        state_q  <= SELECT;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_draw_sequencer.sv
// Directed self-checking bench for draw_sequencer (3 layers).
module tb_draw_sequencer;

    localparam int unsigned NL    = 3;
    localparam int unsigned XW    = 10;
    localparam int unsigned CW    = 3;
    localparam int unsigned CNT_W = 20;

    logic                  clk;
    logic                  reset;
    logic                  enable;
    logic [NL-1:0]         erase_mask;
    logic [NL-1:0]         draw_mask;
    logic [NL*CNT_W-1:0]   layer_delay;
    logic [CNT_W-1:0]      logic_delay;
    logic [NL-1:0]         layer_done;
    logic [NL*XW-1:0]      layer_x;
    logic [NL*XW-1:0]      layer_y;
    logic [NL*CW-1:0]      layer_colour;
    logic [NL-1:0]         layer_en;
    logic                  ovr_active;
    logic [XW-1:0]         ovr_x;
    logic [XW-1:0]         ovr_y;
    logic [CW-1:0]         ovr_colour;
    logic                  ovr_en;
    logic                  clear_overrun;
    logic [NL-1:0]         layer_go;
    logic                  logic_go;
    logic                  inc_enable;
    logic                  pass;
    logic                  busy;
    logic                  overrun;
    logic [XW-1:0]         x;
    logic [XW-1:0]         y;
    logic [CW-1:0]         colour;
    logic                  plot;

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;
    int go1_cnt = 0;
    int at;
    int g;

    draw_sequencer #(
        .NUM_LAYERS (NL),
        .XW         (XW),
        .CW         (CW),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .erase_mask    (erase_mask),
        .draw_mask     (draw_mask),
        .layer_delay   (layer_delay),
        .logic_delay   (logic_delay),
        .layer_done    (layer_done),
        .layer_x       (layer_x),
        .layer_y       (layer_y),
        .layer_colour  (layer_colour),
        .layer_en      (layer_en),
        .ovr_active    (ovr_active),
        .ovr_x         (ovr_x),
        .ovr_y         (ovr_y),
        .ovr_colour    (ovr_colour),
        .ovr_en        (ovr_en),
        .clear_overrun (clear_overrun),
        .layer_go      (layer_go),
        .logic_go      (logic_go),
        .inc_enable    (inc_enable),
        .pass          (pass),
        .busy          (busy),
        .overrun       (overrun),
        .x             (x),
        .y             (y),
        .colour        (colour),
        .plot          (plot)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) begin
        if (layer_go[1]) go1_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic logic sig_of(input int which);
        case (which)
            0, 1, 2: sig_of = layer_go[which];
            3:       sig_of = logic_go;
            4:       sig_of = inc_enable;
            default: sig_of = !busy;
        endcase
    endfunction

    // Returns the cycle at which the signal is first seen high, or -1 if the bound expires.
    task automatic wait_sig(input int which, input int maxc, output int when);
        logic seen;
        seen = 1'b0;
        when = -1;
        for (int k = 0; k < maxc; k++) begin
            if (!seen && sig_of(which)) begin
                seen = 1'b1;
                when = cyc;
            end
            if (!seen) step();
        end
    endtask

    task automatic do_reset();
        enable        = 1'b0;
        erase_mask    = 3'b111;
        draw_mask     = 3'b111;
        layer_delay   = {20'd30, 20'd10, 20'd4};
        logic_delay   = 20'd30;
        layer_done    = 3'b000;
        layer_en      = 3'b111;
        ovr_active    = 1'b0;
        ovr_en        = 1'b0;
        clear_overrun = 1'b0;
        reset         = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic start_frame();
        enable = 1'b1;
        cyc    = 0;
        step();
        enable = 1'b0;
    endtask

    initial begin
        layer_x      = {10'd300, 10'd200, 10'd100};
        layer_y      = {10'd33, 10'd22, 10'd11};
        layer_colour = {3'd6, 3'd5, 3'd3};
        ovr_x        = 10'd512;
        ovr_y        = 10'd77;
        ovr_colour   = 3'd4;
        do_reset();

        // Reset state
        chk("rst_busy", busy, 0);
        chk("rst_overrun", overrun, 0);
        chk("rst_pass", pass, 0);
        chk("rst_plot", plot, 0);
        chk("rst_layer_go", layer_go, 0);
        chk("rst_logic_go", logic_go, 0);
        chk("rst_inc", inc_enable, 0);
        chk("rst_x", x, 100);

        // Full frame, all layers enabled
        start_frame();
        chk("f_busy", busy, 1);
        wait_sig(0, 20, at);
        chk("f_go0_cyc", at, 2);
        chk("f_go0_plot", plot, 1);
        chk("f_go0_black", colour, 0);
        chk("f_go0_x", x, 100);
        chk("f_go0_y", y, 11);
        step();
        chk("f_go0_width", layer_go, 0);
        wait_sig(1, 20, at);
        chk("f_go1_cyc", at, 9);
        chk("f_go1_black", colour, 0);
        chk("f_go1_x", x, 200);
        wait_sig(2, 30, at);
        chk("f_go2_cyc", at, 22);
        wait_sig(3, 60, at);
        chk("f_logic_cyc", at, 55);
        step();
        chk("f_colwait_plot", plot, 0);
        chk("f_colwait_x", x, 300);
        wait_sig(4, 60, at);
        chk("f_inc_cyc", at, 87);
        wait_sig(0, 20, at);
        chk("f_p1_go0_cyc", at, 90);
        chk("f_p1_pass", pass, 1);
        chk("f_p1_colour0", colour, 3);
        chk("f_p1_plot", plot, 1);
        wait_sig(1, 20, at);
        chk("f_p1_go1_cyc", at, 97);
        chk("f_p1_colour1", colour, 5);
        wait_sig(2, 20, at);
        chk("f_p1_go2_cyc", at, 110);
        chk("f_p1_colour2", colour, 6);
        wait_sig(5, 60, at);
        chk("f_idle_cyc", at, 144);
        chk("f_idle_pass", pass, 0);

        // Erase mask skips layer 1 in pass 0 only
        do_reset();
        erase_mask = 3'b101;
        g = go1_cnt;
        start_frame();
        wait_sig(2, 20, at);
        chk("m_go2_cyc", at, 9);
        wait_sig(3, 60, at);
        chk("m_logic_cyc", at, 42);
        chk("m_no_go1_p0", go1_cnt - g, 0);
        wait_sig(4, 60, at);
        chk("m_inc_cyc", at, 74);
        wait_sig(0, 20, at);
        chk("m_p1_go0_cyc", at, 77);
        wait_sig(1, 20, at);
        chk("m_p1_go1_cyc", at, 84);
        wait_sig(5, 60, at);
        chk("m_idle_cyc", at, 131);
        chk("m_go1_p1_once", go1_cnt - g, 1);

        // Early termination of layer 1 in its third DRAW cycle
        do_reset();
        layer_delay = {20'd30, 20'd100, 20'd4};
        start_frame();
        wait_sig(1, 20, at);
        chk("d_go1_cyc", at, 9);
        repeat (3) step();
        layer_done = 3'b010;
        step();
        layer_done = 3'b000;
        chk("d_select_plot", plot, 0);
        wait_sig(2, 20, at);
        chk("d_go2_cyc", at, 14);

        // Overrun on a tick while busy
        do_reset();
        start_frame();
        repeat (4) step();
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("o_set", overrun, 1);
        enable        = 1'b1;
        clear_overrun = 1'b1;
        step();
        enable        = 1'b0;
        clear_overrun = 1'b0;
        chk("o_set_wins", overrun, 1);
        wait_sig(5, 200, at);
        chk("o_idle_cyc", at, 144);
        repeat (3) step();
        chk("o_no_second", busy, 0);
        chk("o_sticky", overrun, 1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        chk("o_cleared", overrun, 0);

        // Override takes the port mid-frame
        do_reset();
        start_frame();
        wait_sig(0, 20, at);
        step();
        ovr_active = 1'b1;
        ovr_en     = 1'b1;
        #1;
        chk("v_plot", plot, 1);
        chk("v_x", x, 512);
        chk("v_y", y, 77);
        chk("v_colour", colour, 4);
        ovr_en = 1'b0;
        #1;
        chk("v_suppressed", plot, 0);
        wait_sig(5, 200, at);
        chk("v_finish_cyc", at, 144);
        enable = 1'b1;
        step();
        enable = 1'b0;
        chk("v_ignored", busy, 0);
        chk("v_no_overrun", overrun, 0);
        ovr_active = 1'b0;
        #1;
        chk("v_idle_plot", plot, 0);
        start_frame();
        chk("v_after_fall", busy, 1);

        // Asynchronous reset during layer 1 DRAW
        do_reset();
        start_frame();
        wait_sig(1, 20, at);
        repeat (3) step();
        chk("r_pre_plot", plot, 1);
        reset = 1'b1;
        #1;
        chk("r_plot", plot, 0);
        chk("r_busy", busy, 0);
        chk("r_layer_go", layer_go, 0);
        chk("r_pass", pass, 0);
        chk("r_x", x, 100);
        @(posedge clk);
        #1;
        reset = 1'b0;
        wait_sig(4, 200, at);
        chk("r_no_inc", at, -1);
        chk("r_still_idle", busy, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/draw_sequencer.md
# draw_sequencer

Parametrised frame sequencer and pixel mux that replaces the fixed three-layer draw controller. Each frame tick runs an erase pass (every layer painted black), then one game-logic step, then a colour pass, granting the shared VGA write port to one layer at a time. It sits between the per-object draw units (ball, bricks, platform, …) and the VGA adapter. An override stream (title/win/lose screens) can take the port.

## Interface
Parameters:
- NUM_LAYERS, 3, number of drawable layers; index 0 is drawn first.
- XW, 10, coordinate width.
- CW, 3, colour width.
- CNT_W, 20, width of the draw-window counter and the delay values.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high.
- enable  in  1  frame tick; one-cycle pulse.
- erase_mask  in  NUM_LAYERS  layers painted during the erase pass.
- draw_mask  in  NUM_LAYERS  layers painted during the colour pass.
- layer_delay  in  NUM_LAYERS*CNT_W  per-layer draw window; layer i uses slice [i*CNT_W +: CNT_W].
- logic_delay  in  CNT_W  wait after logic_go.
- layer_done  in  NUM_LAYERS  early termination of layer i's window.
- layer_x, layer_y  in  NUM_LAYERS*XW  per-layer pixel coordinates.
- layer_colour  in  NUM_LAYERS*CW  per-layer pixel colour.
- layer_en  in  NUM_LAYERS  per-layer plot request.
- ovr_active  in  1  override owns the port.
- ovr_x, ovr_y  in  XW each  override coordinates.
- ovr_colour  in  CW  override colour.
- ovr_en  in  1  override plot request.
- clear_overrun  in  1  clears the overrun flag.
- layer_go  out  NUM_LAYERS  one-cycle start pulse to layer i.
- logic_go  out  1  one-cycle collision/logic strobe.
- inc_enable  out  1  one-cycle position-update strobe.
- pass  out  1  0 = erase pass, 1 = colour pass.
- busy  out  1  high whenever the FSM is outside IDLE.
- overrun  out  1  sticky; set when a frame tick is missed.
- x, y  out  XW each  VGA coordinates.
- colour  out  CW  VGA colour.
- plot  out  1  VGA write enable.

## Operation
- States:
  - IDLE: leave on `enable & ~ovr_active` -> SELECT with pass = 0 and layer index = 0.
  - SELECT: find the lowest enabled layer ≥ index in the current pass's mask.
    - Found: go to LOAD.
    - None found, pass = 0: go to COL.
    - None found, pass = 1: go to CHANGE.
  - LOAD: pulse layer_go[idx] and clear the counter -> DRAW.
  - DRAW: the counter increments every cycle.
    - Leave when `count == layer_delay[idx]` or `layer_done[idx]`.
    - Then set idx += 1 and return to SELECT.
    - If idx was NUM_LAYERS-1, treat SELECT as "none found".
  - COL: pulse logic_go and clear the counter -> COL_WAIT.
  - COL_WAIT: wait until `count == logic_delay` -> INC.
  - INC: pulse inc_enable -> CHANGE.
  - CHANGE: toggle pass.
    - If the new pass is 1: set idx = 0 and go to SELECT.
    - Otherwise go to IDLE.
- Mux:
  - ovr_active = 1: outputs take ovr_* and plot = ovr_en.
  - Otherwise, in LOAD/DRAW: outputs take layer[idx], plot = layer_en[idx], and colour = 0 when pass = 0.
  - All other cases: plot = 0 and x/y/colour hold layer[idx].
- A frame already in progress completes when ovr_active rises, but all of its plots are suppressed.
- Overrun:
  - `enable` while busy sets overrun, and the tick is dropped.
  - clear_overrun clears overrun; if clear_overrun and a missed tick occur in the same cycle, set wins.
- Reset (asynchronous): state = IDLE, pass = 0, idx = 0, count = 0, overrun = 0, and all strobes = 0. plot = 0 unless ovr_active.

## Timing
- Mux output is combinational. Strobes are registered-state decodes, one cycle wide.
- enable in cycle n -> SELECT at n+1 -> layer_go at n+2, assuming layer 0 is enabled.
- A layer's window lasts layer_delay+1 DRAW cycles.
  - layer_delay = 0 gives exactly one DRAW cycle.
  - layer_done in the first DRAW cycle exits immediately.
- A masked-out layer costs 0 cycles; SELECT is a single cycle regardless of the mask.
- SELECT costs 1 cycle per visited layer slot.
- The counter wraps at 2^CNT_W. A delay of all-ones is therefore a 2^CNT_W-cycle window and never hangs.
- Asynchronous reset mid-frame aborts the frame; no strobe fires after reset asserts.

## Structure
- Package `draw_seq_pkg`:
  - state enum (IDLE, SELECT, LOAD, DRAW, COL, COL_WAIT, INC, CHANGE);
  - BLACK = 0;
  - PASS_ERASE / PASS_COLOUR constants.
- Sub-module `draw_window_counter`: CNT_W-bit up-counter with synchronous clear and asynchronous reset.
- The mux stays inline; there is no separate module.

## Test plan
- NUM_LAYERS = 3, all masks 3'b111, delays 4/10/30, logic_delay 30 -> layer_go[0], [1], [2] at cycles 2, 9, 22 after enable; pass-0 writes are black; then logic_go, inc_enable, and the pass-1 sequence.
- erase_mask = 3'b101 -> layer 1 never receives layer_go in pass 0 but does in pass 1; logic_go follows layer 2's window with no gap.
- layer_done[1] asserted in the 3rd DRAW cycle with delay 100 -> layer 2 goes (LOAD) 2 cycles later (via SELECT).
- enable pulsed while busy -> overrun = 1, no second frame; clear_overrun -> overrun = 0.
- ovr_active raised mid-frame -> plot follows ovr_en only; the frame finishes; the next enable is ignored until ovr_active falls.
- reset asserted during DRAW of layer 1 -> outputs go to reset values in the same cycle; no inc_enable is seen.
